// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for the fetch (I) and load/store (D) requesters
// One transaction in flight; ties alternate, misaligned accesses and memory stalls end in an error response.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  i_req,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_W-1:0]     i_rdata,
   output logic                  i_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DATA_W/8-1:0]   d_be,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  d_err,
   output logic                  m_req,
   output logic                  m_we,
   output logic [DATA_W/8-1:0]   m_be,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   input  logic                  m_gnt,
   input  logic                  m_rvalid,
   input  logic [DATA_W-1:0]     m_rdata
);

   localparam int         BE_W = DATA_W / 8;
   localparam logic [7:0] TMO  = 8'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              r_state;
   logic                r_owner;     // 0 = I, 1 = D
   logic                r_last;
   logic                r_mis;       // current RESP is a misaligned reject, which also carries the gnt
   logic [7:0]          r_tcnt;
   logic                r_m_req;
   logic                r_m_we;
   logic [BE_W-1:0]     r_m_be;
   logic [ADDR_W-1:0]   r_m_addr;
   logic [DATA_W-1:0]   r_m_wdata;
   logic                r_i_rvalid;
   logic                r_i_err;
   logic [DATA_W-1:0]   r_i_rdata;
   logic                r_d_rvalid;
   logic                r_d_err;
   logic [DATA_W-1:0]   r_d_rdata;

   logic                w_any;
   logic                w_win;
   logic [ADDR_W-1:0]   w_win_addr;
   logic                w_mis;
   logic                w_take;
   logic                w_tmo_hit;

   assign w_any      = i_req | d_req;
   assign w_win      = (i_req && d_req) ? ~r_last : d_req;
   assign w_win_addr = w_win ? d_addr : i_addr;
   assign w_mis      = |w_win_addr[1:0];
   // In WAIT only an aligned winner is committed; a misaligned one is re-arbitrated from IDLE.
   assign w_take     = w_any && ((r_state == S_IDLE) ||
                                 (r_state == S_WAIT && m_rvalid && !w_mis));
   assign w_tmo_hit  = (r_tcnt == TMO) && ((r_state == S_ISSUE && !m_gnt) ||
                                           (r_state == S_WAIT && !m_rvalid));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_owner    <= 1'b0;
         r_last     <= 1'b0;
         r_mis      <= 1'b0;
         r_tcnt     <= '0;
         r_m_req    <= 1'b0;
         r_m_we     <= 1'b0;
         r_m_be     <= '0;
         r_m_addr   <= '0;
         r_m_wdata  <= '0;
         r_i_rvalid <= 1'b0;
         r_i_err    <= 1'b0;
         r_i_rdata  <= '0;
         r_d_rvalid <= 1'b0;
         r_d_err    <= 1'b0;
         r_d_rdata  <= '0;
      end else begin
         r_i_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_i_err    <= 1'b0;
         r_d_err    <= 1'b0;
         case (r_state)
            S_ISSUE: begin
               r_tcnt <= r_tcnt + 8'd1;
               if (m_gnt) begin
                  r_m_req <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_tcnt <= r_tcnt + 8'd1;
               if (m_rvalid) begin
                  r_state <= S_IDLE;
                  if (r_owner) begin
                     r_d_rvalid <= 1'b1;
                     r_d_rdata  <= m_rdata;
                  end else begin
                     r_i_rvalid <= 1'b1;
                     r_i_rdata  <= m_rdata;
                  end
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_mis   <= 1'b0;
            end
            default: ;
         endcase
         if (w_tmo_hit) begin
            r_m_req <= 1'b0;
            r_mis   <= 1'b0;
            r_state <= S_RESP;
            if (r_owner) begin
               r_d_rvalid <= 1'b1;
               r_d_err    <= 1'b1;
               r_d_rdata  <= '0;
            end else begin
               r_i_rvalid <= 1'b1;
               r_i_err    <= 1'b1;
               r_i_rdata  <= '0;
            end
         end
         if (w_take) begin
            r_owner   <= w_win;
            r_last    <= w_win;
            r_m_we    <= w_win & d_we;
            r_m_be    <= w_win ? d_be : '1;
            r_m_addr  <= w_win_addr;
            r_m_wdata <= w_win ? d_wdata : '0;
            if (w_mis) begin
               r_state <= S_RESP;
               r_mis   <= 1'b1;
               if (w_win) begin
                  r_d_rvalid <= 1'b1;
                  r_d_err    <= 1'b1;
                  r_d_rdata  <= '0;
               end else begin
                  r_i_rvalid <= 1'b1;
                  r_i_err    <= 1'b1;
                  r_i_rdata  <= '0;
               end
            end else begin
               r_state <= S_ISSUE;
               r_m_req <= 1'b1;
               r_tcnt  <= '0;
            end
         end
      end
   end

   assign i_gnt    = !r_owner && ((r_state == S_ISSUE && m_gnt) || (r_state == S_RESP && r_mis));
   assign d_gnt    =  r_owner && ((r_state == S_ISSUE && m_gnt) || (r_state == S_RESP && r_mis));
   assign i_rvalid = r_i_rvalid;
   assign i_rdata  = r_i_rdata;
   assign i_err    = r_i_err;
   assign d_rvalid = r_d_rvalid;
   assign d_rdata  = r_d_rdata;
   assign d_err    = r_d_err;
   assign m_req    = r_m_req;
   assign m_we     = r_m_we;
   assign m_be     = r_m_be;
   assign m_addr   = r_m_addr;
   assign m_wdata  = r_m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Directed scenarios plus a randomized run scored against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int BW  = 4;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          i_req, d_req, d_we, m_gnt, m_rvalid;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata, m_rdata;
   logic [BW-1:0] d_be;
   logic          i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we;
   logic [DW-1:0] i_rdata, d_rdata, m_wdata;
   logic [AW-1:0] m_addr;
   logic [BW-1:0] m_be;
   logic [139:0]  all_out;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct packed {
      logic        who;   // 0 = I, 1 = D
      logic        err;
      logic [31:0] data;
   } rsp_t;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .resetn(resetn),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   assign all_out = {i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
                     m_req, m_we, m_be, m_addr, m_wdata};

   always #5 clk = ~clk;

   task automatic idle_inputs();
      i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
      m_gnt = 0; m_rvalid = 0; m_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 0;
      repeat (2) @(negedge clk);
      resetn = 1;
      @(negedge clk);
   endtask

   // Zero-wait memory; requesters drop req once granted.
   task automatic serve(input int n);
      bit acc = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         m_gnt = m_req; m_rvalid = acc; m_rdata = $urandom;
         #1;
         acc = m_req && m_gnt;
         if (i_gnt) i_req = 0;
         if (d_gnt) d_req = 0;
      end
      m_gnt = 0; m_rvalid = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 0;
      #1;
      n_checks++;
      if (all_out !== '0) begin n_fails++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
      @(negedge clk); resetn = 1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({m_req, i_rvalid, d_rvalid} !== 3'b000) begin
         n_fails++; $display("FAIL reset_idle got=%b exp=000", {m_req, i_rvalid, d_rvalid});
      end
   endtask

   task automatic test_single_fetch();
      i_req = 1; i_addr = 32'h8000_0000;
      @(negedge clk);
      n_checks++;
      if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h8000_0000}) begin
         n_fails++; $display("FAIL fetch_mreq got=%b %b %h", m_req, m_we, m_addr);
      end
      m_gnt = 1; #1;
      n_checks++;
      if ({i_gnt, d_gnt} !== 2'b10) begin n_fails++; $display("FAIL fetch_gnt got=%b exp=10", {i_gnt, d_gnt}); end
      @(negedge clk);
      n_checks++;
      if (i_rvalid !== 1'b0) begin n_fails++; $display("FAIL fetch_early_rvalid got=%b exp=0", i_rvalid); end
      i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0000_0093;
      @(negedge clk);
      m_rvalid = 0;
      n_checks++;
      if ({i_rvalid, i_err, i_rdata, m_req} !== {1'b1, 1'b0, 32'h0000_0093, 1'b0}) begin
         n_fails++; $display("FAIL fetch_resp got=%b %b %h %b exp=1 0 00000093 0", i_rvalid, i_err, i_rdata, m_req);
      end
      @(negedge clk);
   endtask

   task automatic test_tie_after_reset();
      do_reset();
      i_req = 1; i_addr = 32'h8000_0000;
      d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
      @(negedge clk);
      n_checks++;
      if ({m_req, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF}) begin
         n_fails++; $display("FAIL tie_first_is_d got=%b %b %h %h", m_req, m_we, m_addr, m_wdata);
      end
      m_gnt = 1; #1;
      n_checks++;
      if ({d_gnt, i_gnt} !== 2'b10) begin n_fails++; $display("FAIL tie_dgnt got=%b exp=10", {d_gnt, i_gnt}); end
      @(negedge clk);
      d_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h1122_3344;
      @(negedge clk);
      m_rvalid = 0;
      n_checks++;
      if ({d_rvalid, d_err, d_rdata} !== {1'b1, 1'b0, 32'h1122_3344}) begin
         n_fails++; $display("FAIL tie_dresp got=%b %b %h exp=1 0 11223344", d_rvalid, d_err, d_rdata);
      end
      n_checks++;
      if ({m_req, m_we, m_be, m_addr, m_wdata} !== {1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0}) begin
         n_fails++; $display("FAIL tie_i_b2b got=%b %b %h %h %h", m_req, m_we, m_be, m_addr, m_wdata);
      end
      m_gnt = 1; #1;
      n_checks++;
      if ({i_gnt, d_gnt} !== 2'b10) begin n_fails++; $display("FAIL tie_igtn got=%b exp=10", {i_gnt, d_gnt}); end
      @(negedge clk);
      i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0000_0013;
      @(negedge clk);
      m_rvalid = 0;
      n_checks++;
      if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, 32'h13, 1'b0}) begin
         n_fails++; $display("FAIL tie_iresp got=%b %h %b", i_rvalid, i_rdata, d_rvalid);
      end
      @(negedge clk);
      n_checks++;
      if (i_rvalid !== 1'b0) begin n_fails++; $display("FAIL tie_ipulse got=%b exp=0", i_rvalid); end
   endtask

   task automatic test_starvation();
      bit acc = 0;
      int gcyc[$];
      bit gwho[$];
      do_reset();
      i_req = 1; i_addr = 32'h8000_0020; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (c >= 12) begin i_req = 0; d_req = 0; end
         m_gnt = m_req; m_rvalid = acc; m_rdata = 32'(c);
         #1;
         acc = m_req && m_gnt;
         if (i_gnt && d_gnt) begin
            n_checks++; n_fails++; $display("FAIL starve_both_gnt cycle=%0d", c);
         end
         if (i_gnt || d_gnt) begin gcyc.push_back(c); gwho.push_back(d_gnt); end
      end
      m_gnt = 0; m_rvalid = 0;
      n_checks++;
      if (gcyc.size() != 6) begin n_fails++; $display("FAIL starve_count got=%0d exp=6", gcyc.size()); end
      for (int k = 0; k < 6 && k < gcyc.size(); k++) begin
         n_checks++;
         if (gwho[k] !== ((k % 2) == 0) || gcyc[k] != 1 + 2 * k) begin
            n_fails++;
            $display("FAIL starve_grant%0d got=who%0d@%0d exp=who%0d@%0d", k, gwho[k], gcyc[k], (k % 2) == 0, 1 + 2 * k);
         end
      end
   endtask

   task automatic test_misaligned();
      d_req = 1; d_we = 0; d_addr = 32'h102;
      @(negedge clk);
      n_checks++;
      if ({m_req, d_rvalid, d_err, d_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
         n_fails++; $display("FAIL misaligned_resp got=%b %b %b %h exp=0 1 1 0", m_req, d_rvalid, d_err, d_rdata);
      end
      #1;
      n_checks++;
      if ({d_gnt, i_gnt} !== 2'b10) begin n_fails++; $display("FAIL misaligned_gnt got=%b exp=10", {d_gnt, i_gnt}); end
      d_req = 0;
      @(negedge clk);
      n_checks++;
      if ({d_rvalid, d_gnt, m_req} !== 3'b000) begin
         n_fails++; $display("FAIL misaligned_after got=%b exp=000", {d_rvalid, d_gnt, m_req});
      end
   endtask

   task automatic test_timeout();
      int  hi = 0;
      int  at = -1;
      bit  gnt_seen = 0;
      i_req = 1; i_addr = 32'h8000_0010;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (m_req) hi++;
         if (i_rvalid && at < 0) begin
            at = c;
            n_checks++;
            if ({i_err, i_rdata, hi} !== {1'b1, 32'h0, 32'd5}) begin
               n_fails++; $display("FAIL timeout_issue_resp got=err%b %h hi%0d exp=err1 0 hi5", i_err, i_rdata, hi);
            end
            i_req = 0;
         end
         #1;
         if (i_gnt) gnt_seen = 1;
      end
      n_checks++;
      if (at != 6) begin n_fails++; $display("FAIL timeout_issue_cycle got=%0d exp=6", at); end
      n_checks++;
      if (gnt_seen || hi != 5) begin n_fails++; $display("FAIL timeout_issue_nognt got=gnt%0d hi%0d exp=gnt0 hi5", gnt_seen, hi); end
      // memory accepts, then never responds
      d_req = 1; d_we = 0; d_addr = 32'h300;
      @(negedge clk);
      m_gnt = 1; #1;
      n_checks++;
      if (d_gnt !== 1'b1) begin n_fails++; $display("FAIL timeout_wait_gnt got=%b exp=1", d_gnt); end
      @(negedge clk);
      m_gnt = 0; d_req = 0;
      at = -1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (d_rvalid && at < 0) begin
            at = c;
            n_checks++;
            if ({d_err, d_rdata} !== {1'b1, 32'h0}) begin
               n_fails++; $display("FAIL timeout_wait_resp got=%b %h exp=1 0", d_err, d_rdata);
            end
         end
         if (c == 6) begin m_rvalid = 1; m_rdata = 32'h0000_0BAD; end
         if (c == 7) m_rvalid = 0;
         if (c >= 7) begin
            n_checks++;
            if ({d_rvalid, i_rvalid} !== 2'b00) begin
               n_fails++; $display("FAIL late_rvalid_ignored got=%b exp=00", {d_rvalid, i_rvalid});
            end
         end
      end
      n_checks++;
      if (at != 4) begin n_fails++; $display("FAIL timeout_wait_cycle got=%0d exp=4", at); end
   endtask

   task automatic test_reset_mid_wait();
      d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h100; d_wdata = 32'h5555_AAAA;
      @(negedge clk);
      m_gnt = 1; #1;
      @(negedge clk);
      m_gnt = 0; d_req = 0;
      n_checks++;
      if (m_addr !== 32'h100) begin n_fails++; $display("FAIL rstwait_pre got=%h exp=100", m_addr); end
      resetn = 0; m_rvalid = 1; m_rdata = 32'h7777_7777;
      #1;
      n_checks++;
      if (all_out !== '0) begin n_fails++; $display("FAIL rstwait_outputs got=%h exp=0", all_out); end
      @(negedge clk);
      m_rvalid = 0; resetn = 1;
      @(negedge clk);
      n_checks++;
      if (all_out !== '0) begin n_fails++; $display("FAIL rstwait_no_stale got=%h exp=0", all_out); end
      i_req = 1; i_addr = 32'h8000_0040; d_req = 1; d_we = 0; d_addr = 32'h104;
      @(negedge clk);
      n_checks++;
      if ({m_req, m_addr} !== {1'b1, 32'h104}) begin
         n_fails++; $display("FAIL rstwait_tie_d got=%b %h exp=1 104", m_req, m_addr);
      end
      serve(10);
   endtask

   task automatic test_random();
      rsp_t exp_q[$];
      rsp_t e;
      rsp_t got;
      bit   pend = 0;
      int   pcnt = 0;
      int   iss_wait = 0;
      logic [31:0] pdata = '0;
      bit   pg_i = 0, pg_d = 0;
      int   skip_i = 0, skip_d = 0;
      bit   quiet = 0;
      idle_inputs();
      for (int cyc = 0; cyc < 1400 && !quiet; cyc++) begin
         @(negedge clk);
         if (cyc < 1200 && !i_req && $urandom_range(0, 2) == 0) begin
            i_req = 1; i_addr = $urandom;
            if ($urandom_range(0, 5) != 0) i_addr[1:0] = 2'b00;
         end
         if (cyc < 1200 && !d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_addr = $urandom; d_we = 1'($urandom); d_be = 4'($urandom); d_wdata = $urandom;
            if ($urandom_range(0, 5) != 0) d_addr[1:0] = 2'b00;
         end
         m_gnt = 0; m_rvalid = 0; m_rdata = $urandom;
         if (pend) begin
            if (pcnt == 0) begin m_rvalid = 1; m_rdata = pdata; pend = 0; end
            else pcnt--;
         end else if (m_req) begin
            if (iss_wait >= 1 || $urandom_range(0, 1) == 1) m_gnt = 1;
            else iss_wait++;
         end else begin
            if ($urandom_range(0, 7) == 0) m_rvalid = 1;
            if ($urandom_range(0, 7) == 0) m_gnt = 1;
         end
         #1;
         n_checks++;
         if (m_req && m_addr[1:0] != 2'b00) begin n_fails++; $display("FAIL rnd_misaligned_mreq addr=%h", m_addr); end
         n_checks++;
         if (i_gnt && d_gnt) begin n_fails++; $display("FAIL rnd_both_gnt cycle=%0d", cyc); end
         if (i_gnt) begin
            n_checks++;
            if (pg_i || skip_i > 1) begin n_fails++; $display("FAIL rnd_igtn_rule cycle=%0d consec=%0d skipped=%0d", cyc, pg_i, skip_i); end
            if (d_req) skip_d++;
            skip_i = 0;
            if (i_addr[1:0] != 2'b00) begin
               n_checks++;
               if (m_req !== 1'b0) begin n_fails++; $display("FAIL rnd_i_mis_mreq got=%b exp=0", m_req); end
               exp_q.push_back('{1'b0, 1'b1, 32'h0});
            end else begin
               n_checks++;
               if ({m_req, m_gnt, m_addr, m_we, m_be, m_wdata} !== {1'b1, 1'b1, i_addr, 1'b0, 4'hF, 32'h0}) begin
                  n_fails++; $display("FAIL rnd_i_fields got=%b %h %b %h %h exp addr=%h", m_req, m_addr, m_we, m_be, m_wdata, i_addr);
               end
               pdata = $urandom; pend = 1; pcnt = $urandom_range(0, 1); iss_wait = 0;
               exp_q.push_back('{1'b0, 1'b0, pdata});
            end
            i_req = 0;
         end
         if (d_gnt) begin
            n_checks++;
            if (pg_d || skip_d > 1) begin n_fails++; $display("FAIL rnd_dgnt_rule cycle=%0d consec=%0d skipped=%0d", cyc, pg_d, skip_d); end
            if (i_req) skip_i++;
            skip_d = 0;
            if (d_addr[1:0] != 2'b00) begin
               n_checks++;
               if (m_req !== 1'b0) begin n_fails++; $display("FAIL rnd_d_mis_mreq got=%b exp=0", m_req); end
               exp_q.push_back('{1'b1, 1'b1, 32'h0});
            end else begin
               n_checks++;
               if ({m_req, m_gnt, m_addr, m_we, m_be, m_wdata} !== {1'b1, 1'b1, d_addr, d_we, d_be, d_wdata}) begin
                  n_fails++; $display("FAIL rnd_d_fields got=%b %h %b %h %h exp addr=%h", m_req, m_addr, m_we, m_be, m_wdata, d_addr);
               end
               pdata = $urandom; pend = 1; pcnt = $urandom_range(0, 1); iss_wait = 0;
               exp_q.push_back('{1'b1, 1'b0, pdata});
            end
            d_req = 0;
         end
         pg_i = i_gnt; pg_d = d_gnt;
         n_checks++;
         if (i_rvalid && d_rvalid) begin n_fails++; $display("FAIL rnd_both_rvalid cycle=%0d", cyc); end
         if (i_rvalid || d_rvalid) begin
            got = d_rvalid ? rsp_t'{1'b1, d_err, d_rdata} : rsp_t'{1'b0, i_err, i_rdata};
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fails++; $display("FAIL rnd_unexpected_rvalid got=%h", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin n_fails++; $display("FAIL rnd_response got=%h exp=%h", got, e); end
            end
         end
         quiet = (cyc >= 1200) && !i_req && !d_req && !pend && !m_req && exp_q.size() == 0;
      end
      m_gnt = 0; m_rvalid = 0;
      n_checks++;
      if (!quiet) begin n_fails++; $display("FAIL rnd_drain pending=%0d i_req=%b d_req=%b", exp_q.size(), i_req, d_req); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_tie_after_reset();
      test_single_fetch();
      test_starvation();
      test_misaligned();
      test_timeout();
      test_single_fetch();
      test_reset_mid_wait();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
